// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central hazard controller for the 5-stage integer pipeline.
//            Each cycle it drives the latch controls of IF/ID, ID/EX, EX/MEM
//            and MEM/WB, plus the PC write enable and source select.
//            Hazards are resolved with a fixed priority:
//              trap > mem_wait > drain > multi-cycle busy > branch redirect >
//              multi-cycle start > load-use.
//            A saturating counter records cycles in which the PC was held.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   MC_LAT     total EX occupancy of a multi-cycle op, incl. start (2..16)
//   DRAIN_CYC  fetch-hold cycles after trap entry (0..15)
//   CNT_W      stall counter width
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   load_use     ID depends on the load currently in EX
//   br_redirect  EX resolved a mispredicted / taken branch
//   mc_start     EX holds a multi-cycle op in its first cycle
//   mem_wait     MEM stage not ready
//   trap         trap / exception taken this cycle
//   ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb
//                latch control: 00 normal, 01 squash, 10 stall
//   pc_en        PC write enable
//   pc_sel       PC source: 00 sequential, 01 branch target, 10 trap vector
//   busy         controller is in MCBUSY or DRAIN
//   stall_cnt    cycles with pc_en=0, saturating
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MC_LAT    = 4,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             br_redirect,
  input  logic             mc_start,
  input  logic             mem_wait,
  input  logic             trap,
  output logic [1:0]       ctr_ifid,
  output logic [1:0]       ctr_idex,
  output logic [1:0]       ctr_exmem,
  output logic [1:0]       ctr_memwb,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MCBUSY = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [1:0] c_ctr_norm   = 2'b00;
  localparam logic [1:0] c_ctr_squash = 2'b01;
  localparam logic [1:0] c_ctr_stall  = 2'b10;

  localparam logic [1:0] c_pc_seq  = 2'b00;
  localparam logic [1:0] c_pc_br   = 2'b01;
  localparam logic [1:0] c_pc_trap = 2'b10;

  // The start cycle and the release cycle are not counted by cnt, so the
  // MCBUSY stall phase lasts MC_LAT-2 cycles. DRAIN counts down to zero
  // inclusive, hence DRAIN_CYC-1.
  localparam logic [3:0] c_mc_init    = 4'(MC_LAT - 2);
  localparam logic [3:0] c_drain_init = (DRAIN_CYC > 0) ? 4'(DRAIN_CYC - 1) : 4'd0;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_cnt;
  logic [3:0]       w_next_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    ctr_ifid     = c_ctr_norm;
    ctr_idex     = c_ctr_norm;
    ctr_exmem    = c_ctr_norm;
    ctr_memwb    = c_ctr_norm;
    pc_en        = 1'b1;
    pc_sel       = c_pc_seq;

    if (!rst) begin
      // Outputs are forced while reset is held; state is cleared by the
      // asynchronous reset of the register process.
      ctr_ifid  = c_ctr_squash;
      ctr_idex  = c_ctr_squash;
      ctr_exmem = c_ctr_squash;
      ctr_memwb = c_ctr_squash;
      pc_en     = 1'b0;
    end else if (trap) begin
      // Trap flushes everything and aborts any multi-cycle op.
      ctr_ifid  = c_ctr_squash;
      ctr_idex  = c_ctr_squash;
      ctr_exmem = c_ctr_squash;
      ctr_memwb = c_ctr_squash;
      pc_sel    = c_pc_trap;
      if (DRAIN_CYC > 0) begin
        w_next_state = ST_DRAIN;
        w_next_cnt   = c_drain_init;
      end else begin
        w_next_state = ST_RUN;
        w_next_cnt   = 4'd0;
      end
    end else if (mem_wait) begin
      // Hold everything upstream of MEM, bubble into WB; state frozen.
      ctr_ifid  = c_ctr_stall;
      ctr_idex  = c_ctr_stall;
      ctr_exmem = c_ctr_stall;
      ctr_memwb = c_ctr_squash;
      pc_en     = 1'b0;
    end else begin
      case (r_state)
        ST_DRAIN: begin
          ctr_ifid = c_ctr_squash;
          pc_en    = 1'b0;
          if (r_cnt == 4'd0) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_cnt = r_cnt - 4'd1;
          end
        end

        ST_MCBUSY: begin
          if (r_cnt != 4'd0) begin
            ctr_ifid   = c_ctr_stall;
            ctr_idex   = c_ctr_stall;
            ctr_exmem  = c_ctr_squash;
            pc_en      = 1'b0;
            w_next_cnt = r_cnt - 4'd1;
          end else begin
            // Release cycle: the op leaves EX now. A dependent load is
            // still honoured; a branch or new MC op cannot be in EX yet.
            w_next_state = ST_RUN;
            if (load_use) begin
              ctr_ifid = c_ctr_stall;
              ctr_idex = c_ctr_squash;
              pc_en    = 1'b0;
            end
          end
        end

        default: begin
          if (br_redirect) begin
            ctr_ifid = c_ctr_squash;
            ctr_idex = c_ctr_squash;
            pc_sel   = c_pc_br;
          end else if (mc_start) begin
            ctr_ifid     = c_ctr_stall;
            ctr_idex     = c_ctr_stall;
            ctr_exmem    = c_ctr_squash;
            pc_en        = 1'b0;
            w_next_state = ST_MCBUSY;
            w_next_cnt   = c_mc_init;
          end else if (load_use) begin
            ctr_ifid = c_ctr_stall;
            ctr_idex = c_ctr_squash;
            pc_en    = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // State is already a register, so this decode follows entry/exit by one
  // cycle as seen from the triggering input.
  assign busy      = (r_state != ST_RUN);
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed, self-checking bench for pipe_hazard_ctrl. The driver
//            applies one input vector per cycle and queues the hand-computed
//            response; a monitor pops and compares on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int c_mc_lat    = 4;
  localparam int c_drain_cyc = 2;
  localparam int c_cnt_w     = 4;

  // Packed latch controls {ifid, idex, exmem, memwb}
  localparam logic [7:0] c_nrm = 8'b00_00_00_00;
  localparam logic [7:0] c_lu  = 8'b10_01_00_00;
  localparam logic [7:0] c_br  = 8'b01_01_00_00;
  localparam logic [7:0] c_mc  = 8'b10_10_01_00;
  localparam logic [7:0] c_mw  = 8'b10_10_10_01;
  localparam logic [7:0] c_all = 8'b01_01_01_01;
  localparam logic [7:0] c_dr  = 8'b01_00_00_00;

  logic               clk;
  logic               rst;
  logic               load_use, br_redirect, mc_start, mem_wait, trap;
  logic [1:0]         ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb;
  logic               pc_en;
  logic [1:0]         pc_sel;
  logic               busy;
  logic [c_cnt_w-1:0] stall_cnt;

  typedef struct {
    string      name;
    logic [7:0] ctr;
    logic       pe;
    logic [1:0] ps;
    logic       bsy;
    int         sc;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  pipe_hazard_ctrl #(
    .MC_LAT    (c_mc_lat),
    .DRAIN_CYC (c_drain_cyc),
    .CNT_W     (c_cnt_w)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_use    (load_use),
    .br_redirect (br_redirect),
    .mc_start    (mc_start),
    .mem_wait    (mem_wait),
    .trap        (trap),
    .ctr_ifid    (ctr_ifid),
    .ctr_idex    (ctr_idex),
    .ctr_exmem   (ctr_exmem),
    .ctr_memwb   (ctr_memwb),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .busy        (busy),
    .stall_cnt   (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are stable mid-cycle, one expectation per driven cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [7:0] act_ctr;
      e       = q.pop_front();
      act_ctr = {ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb};
      n_vec++;
      if (act_ctr !== e.ctr || pc_en !== e.pe || pc_sel !== e.ps ||
          busy !== e.bsy || stall_cnt !== c_cnt_w'(e.sc)) begin
        n_miss++;
        $display("FAIL %s: got ctr=%b pc_en=%b pc_sel=%b busy=%b stall_cnt=%0d, want ctr=%b pc_en=%b pc_sel=%b busy=%b stall_cnt=%0d",
                 e.name, act_ctr, pc_en, pc_sel, busy, stall_cnt,
                 e.ctr, e.pe, e.ps, e.bsy, e.sc);
      end
    end
  end

  task automatic push(input string name, input logic [7:0] ctr, input logic pe,
                      input logic [1:0] ps, input logic bsy, input int sc);
    exp_t e;
    e.name = name; e.ctr = ctr; e.pe = pe; e.ps = ps; e.bsy = bsy; e.sc = sc;
    q.push_back(e);
  endtask

  // One cycle: inputs {lu, br, mc, mw, tp} plus the expected response.
  task automatic vec(input string name, input logic lu, input logic br,
                     input logic mc, input logic mw, input logic tp,
                     input logic [7:0] ctr, input logic pe, input logic [1:0] ps,
                     input logic bsy, input int sc);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    load_use    = lu;
    br_redirect = br;
    mc_start    = mc;
    mem_wait    = mw;
    trap        = tp;
    push(name, ctr, pe, ps, bsy, sc);
  endtask

  // Reset asserted between edges; outputs must react before the next edge.
  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    load_use    = 1'b0;
    br_redirect = 1'b0;
    mc_start    = 1'b0;
    mem_wait    = 1'b0;
    trap        = 1'b0;
    push(name, c_all, 1'b0, 2'b00, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load_use = 1'b0; br_redirect = 1'b0;
    mc_start = 1'b0; mem_wait = 1'b0; trap = 1'b0;

    // Reset state, then idle
    do_reset("reset_state");
    for (int i = 0; i < 10; i++)
      vec("idle", 0,0,0,0,0, c_nrm, 1, 2'b00, 0, 0);

    // Load-use, then branch overriding load-use
    vec("lu_stall",   1,0,0,0,0, c_lu,  0, 2'b00, 0, 0);
    vec("lu_after",   0,0,0,0,0, c_nrm, 1, 2'b00, 0, 1);
    vec("br_over_lu", 1,1,0,0,0, c_br,  1, 2'b01, 0, 1);
    vec("br_after",   0,0,0,0,0, c_nrm, 1, 2'b00, 0, 1);

    // Multi-cycle op, plain
    do_reset("reset_mc");
    vec("mc_start",   0,0,1,0,0, c_mc,  0, 2'b00, 0, 0);
    vec("mc_busy2",   0,0,0,0,0, c_mc,  0, 2'b00, 1, 1);
    vec("mc_busy1",   0,0,0,0,0, c_mc,  0, 2'b00, 1, 2);
    vec("mc_release", 0,0,0,0,0, c_nrm, 1, 2'b00, 1, 3);
    vec("mc_done",    0,0,0,0,0, c_nrm, 1, 2'b00, 0, 3);

    // Multi-cycle op stretched by mem_wait; release with lu+br+mc asserted
    vec("mcw_start",  0,0,1,0,0, c_mc,  0, 2'b00, 0, 3);
    vec("mcw_wait1",  0,0,0,1,0, c_mw,  0, 2'b00, 1, 4);
    vec("mcw_wait2",  0,0,0,1,0, c_mw,  0, 2'b00, 1, 5);
    vec("mcw_busy2",  0,0,0,0,0, c_mc,  0, 2'b00, 1, 6);
    vec("mcw_busy1",  0,0,0,0,0, c_mc,  0, 2'b00, 1, 7);
    vec("mcw_rel_lu", 1,1,1,0,0, c_lu,  0, 2'b00, 1, 8);
    vec("mcw_done",   0,0,0,0,0, c_nrm, 1, 2'b00, 0, 9);

    // Trap during MCBUSY (and during mem_wait), then DRAIN ignoring branch
    do_reset("reset_trap");
    vec("tr_mc_start", 0,0,1,0,0, c_mc,  0, 2'b00, 0, 0);
    vec("tr_mc_busy",  0,0,0,0,0, c_mc,  0, 2'b00, 1, 1);
    vec("tr_trap",     0,0,0,1,1, c_all, 1, 2'b10, 1, 2);
    vec("tr_drain1",   0,1,0,0,0, c_dr,  0, 2'b00, 1, 2);
    vec("tr_drain0",   0,1,1,0,0, c_dr,  0, 2'b00, 1, 3);
    vec("tr_run",      0,0,0,0,0, c_nrm, 1, 2'b00, 0, 4);

    // Trap from RUN, mem_wait freezes DRAIN
    vec("tr2_trap",    0,0,0,0,1, c_all, 1, 2'b10, 0, 4);
    vec("tr2_mw",      0,0,0,1,0, c_mw,  0, 2'b00, 1, 4);
    vec("tr2_drain1",  0,0,0,0,0, c_dr,  0, 2'b00, 1, 5);
    vec("tr2_drain0",  0,0,0,0,0, c_dr,  0, 2'b00, 1, 6);
    vec("tr2_run",     0,0,0,0,0, c_nrm, 1, 2'b00, 0, 7);

    // Asynchronous reset mid-MCBUSY, then a full MC sequence
    do_reset("reset_ar");
    vec("ar_mc_start", 0,0,1,0,0, c_mc,  0, 2'b00, 0, 0);
    vec("ar_mc_busy",  0,0,0,0,0, c_mc,  0, 2'b00, 1, 1);
    do_reset("ar_mid_reset");
    vec("ar2_start",   0,0,1,0,0, c_mc,  0, 2'b00, 0, 0);
    vec("ar2_busy2",   0,0,0,0,0, c_mc,  0, 2'b00, 1, 1);
    vec("ar2_busy1",   0,0,0,0,0, c_mc,  0, 2'b00, 1, 2);
    vec("ar2_release", 0,0,0,0,0, c_nrm, 1, 2'b00, 1, 3);
    vec("ar2_done",    0,0,0,0,0, c_nrm, 1, 2'b00, 0, 3);

    // Stall counter saturation at 2^4-1
    do_reset("reset_sat");
    for (int i = 0; i < 20; i++)
      vec("sat_lu", 1,0,0,0,0, c_lu, 0, 2'b00, 0, (i > 15) ? 15 : i);
    vec("sat_hold1", 0,0,0,0,0, c_nrm, 1, 2'b00, 0, 15);
    vec("sat_hold2", 0,0,0,0,0, c_nrm, 1, 2'b00, 0, 15);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard controller for the 5-stage integer pipeline. Each cycle it drives the 2-bit control input of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write/select. It resolves load-use hazards, branch redirects, multi-cycle EX operations, memory wait and trap entry with a fixed priority. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- MC_LAT, 4: total EX occupancy of a multi-cycle op in cycles, including the start cycle; legal range 2..16.
- DRAIN_CYC, 2: fetch-hold cycles after trap entry; legal range 0..15.
- CNT_W, 16: width of the stall counter.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- load_use  input  1  ID instruction depends on the load currently in EX.
- br_redirect  input  1  EX resolved a mispredicted or taken branch.
- mc_start  input  1  EX holds a multi-cycle op in its first cycle.
- mem_wait  input  1  MEM stage is not ready; the memory op must hold.
- trap  input  1  trap or exception taken this cycle.
- ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb  output  2 each  latch control: 00 normal, 01 squash, 10 stall.
- pc_en  output  1  PC register write enable.
- pc_sel  output  2  PC source: 00 sequential, 01 branch target, 10 trap vector.
- busy  output  1  state is MCBUSY or DRAIN.
- stall_cnt  output  CNT_W  count of cycles with pc_en=0, saturating at all-ones.

## Operation
- States: RUN, MCBUSY, DRAIN. A 4-bit down-counter `cnt` is shared by MCBUSY and DRAIN.
- Outputs are combinational from state, `cnt` and the inputs. Unless stated otherwise, each ctr is 00, pc_en=1 and pc_sel=00.
- Priority, highest first, in any state:
  1. trap
     - All four ctr = 01; pc_sel=10; pc_en=1.
     - Any MC op is aborted.
     - If DRAIN_CYC>0: go to DRAIN with cnt=DRAIN_CYC-1. Otherwise go to RUN.
  2. mem_wait
     - ctr_ifid, ctr_idex, ctr_exmem = 10; ctr_memwb = 01; pc_en=0.
     - State and cnt are frozen.
  3. DRAIN
     - ctr_ifid=01; pc_en=0.
     - If cnt==0: go to RUN. Otherwise decrement cnt.
     - All other inputs are ignored.
  4. MCBUSY
     - If cnt!=0: ctr_ifid=10, ctr_idex=10, ctr_exmem=01, pc_en=0; decrement cnt.
     - If cnt==0 (release cycle): go to RUN and evaluate load_use exactly as in RUN. br_redirect and mc_start are ignored in this cycle.
  5. RUN, br_redirect
     - ctr_ifid=01, ctr_idex=01; pc_sel=01; pc_en=1.
     - Overrides load_use and mc_start.
  6. RUN, mc_start
     - ctr_ifid=10, ctr_idex=10, ctr_exmem=01; pc_en=0.
     - Go to MCBUSY with cnt=MC_LAT-2. load_use is ignored.
  7. RUN, load_use
     - ctr_ifid=10, ctr_idex=01; pc_en=0.
- Stall counter: stall_cnt increments on every cycle with pc_en=0 and rst=1. It holds at 2^CNT_W-1.

## Timing
- Reset (rst=0), asynchronous:
  - state=RUN, cnt=0, stall_cnt=0.
  - While rst=0, all ctr=01, pc_en=0, pc_sel=00, busy=0.
  - Reset mid-MCBUSY or mid-DRAIN abandons the operation immediately.
- Latency:
  - Control outputs respond to inputs in the same cycle (zero latency).
  - State and counter update at the next rising edge.
- A multi-cycle op occupies EX for exactly MC_LAT cycles: start cycle + (MC_LAT-2) MCBUSY stall cycles + 1 release cycle. ctr_exmem=00 only in the release cycle.
- mem_wait during MCBUSY extends the op by one cycle per asserted cycle (cnt frozen).
- trap during mem_wait: trap wins, all latches squash.
- A load_use pulse held for N cycles produces N stall cycles.
- busy is registered from state: it asserts the cycle after entry to MCBUSY/DRAIN and deasserts the cycle after exit.

## Test plan
- Reset release, no hazards: all ctr=00, pc_en=1, pc_sel=00, stall_cnt stays 0 for 10 cycles.
- load_use for 1 cycle in RUN:
  - Required: ctr_ifid=10, ctr_idex=01, pc_en=0 that cycle; normal outputs next cycle.
  - Then br_redirect together with load_use: ctr_ifid=01, ctr_idex=01, pc_sel=01, pc_en=1.
- mc_start with MC_LAT=4:
  - Required: 3 cycles of ctr_exmem=01 and pc_en=0, then a release cycle with all ctr=00; busy high for cycles 2-4; stall_cnt=3.
  - Repeat with mem_wait for 2 cycles mid-op: pc_en=0 for 5 cycles, ctr_memwb=01 during the wait cycles.
- trap during MCBUSY with DRAIN_CYC=2:
  - Required: all ctr=01 and pc_sel=10 in the trap cycle.
  - Then 2 DRAIN cycles with ctr_ifid=01 and pc_en=0, ignoring a br_redirect asserted in DRAIN.
  - Then RUN.
- Async reset asserted mid-MCBUSY, between clock edges:
  - Required: outputs switch to all ctr=01, pc_en=0 immediately; stall_cnt=0.
  - After release, state is RUN and a subsequent mc_start gives the full MC_LAT sequence.
- CNT_W=4: hold load_use for 20 cycles -> stall_cnt saturates and holds at 15.
